dmem_responder: RTL and testbench

- Data-memory responder for the pipelined MIPS core. It services the M-stage data interface: address on ALUOutM, write data on WriteDataM, and the MemWriteM/MemReadM strobes.
- Models a word-addressed RAM with programmable wait states. It returns ReadDataM and drives MemStallM back to the hazard unit so the core holds F/D/E/M while an access is in flight.
- Sits outside the core, at the responder end of the data-memory port.

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with programmable wait states, answering the M-stage data port of the core.
// Optional access/stall statistics are compiled in with `define DMEM_STATS_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemDoneM,
    output logic        MemErrM
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] ReadCount,
    output logic [31:0] WriteCount,
    output logic [31:0] StallCount
`endif
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic          bad_q, bad_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_out_q, err_out_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          mem_we;
    logic          req;
    logic          misaligned;
    logic          out_of_range;
    logic          access_fire;

    assign req          = MemReadM | MemWriteM;
    assign misaligned   = |ALUOutM[1:0];
    assign out_of_range = {1'b0, ALUOutM} >= LIMIT;
    assign access_fire  = (state_q == BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        bad_d     = bad_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_out_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(WAIT_STATES);
                    addr_d  = ALUOutM[AW+1:2];
                    data_d  = WriteDataM;
                    // A simultaneous read+write is serviced as a write but still flagged.
                    wr_d    = MemWriteM;
                    bad_d   = misaligned | out_of_range;
                    err_d   = misaligned | out_of_range | (MemReadM & MemWriteM);
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    err_out_d = err_q;
                    if (wr_q) begin
                        mem_we = ~bad_q;
                    end else begin
                        rdata_d = bad_q ? 32'd0 : mem[addr_q];
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= 32'd0;
            wr_q      <= 1'b0;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
        end
    end

    // RAM keeps its contents across reset; a reset on the access edge aborts the store.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_q] <= data_q;
        end
    end

    assign ReadDataM = rdata_q;
    assign MemDoneM  = done_q;
    assign MemErrM   = err_out_q;
    assign MemStallM = ((state_q == IDLE) && req) || (state_q == BUSY);

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        st_cnt_d = st_cnt_q;
        if (access_fire && !err_q && !wr_q && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (access_fire && !err_q && wr_q && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (MemStallM && (st_cnt_q != 32'hFFFF_FFFF)) begin
            st_cnt_d = st_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
            st_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign ReadCount  = rd_cnt_q;
    assign WriteCount = wr_cnt_q;
    assign StallCount = st_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by directed and random accesses,
// responses checked against a word-array memory model through per-instance expected queues.
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
    localparam int          WS0   = 2;
    localparam int          WS1   = 0;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        done  [2];
    logic        err   [2];
    logic [31:0] rc    [2];
    logic [31:0] wc    [2];
    logic [31:0] sc    [2];

    int checks   = 0;
    int failures = 0;

    // {data_dont_care, err, read_data}
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];

    logic [31:0] mem_m      [2][DEPTH];
    bit          known_m    [2][DEPTH];
    logic [31:0] last_rd    [2];
    bit          last_known [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .reset(rst[0]), .MemReadM(rd[0]), .MemWriteM(wr[0]),
        .ALUOutM(addr[0]), .WriteDataM(wdata[0]), .ReadDataM(rdata[0]),
        .MemStallM(stall[0]), .MemDoneM(done[0]), .MemErrM(err[0])
`ifdef DMEM_STATS_EN
        , .ReadCount(rc[0]), .WriteCount(wc[0]), .StallCount(sc[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .reset(rst[1]), .MemReadM(rd[1]), .MemWriteM(wr[1]),
        .ALUOutM(addr[1]), .WriteDataM(wdata[1]), .ReadDataM(rdata[1]),
        .MemStallM(stall[1]), .MemDoneM(done[1]), .MemErrM(err[1])
`ifdef DMEM_STATS_EN
        , .ReadCount(rc[1]), .WriteCount(wc[1]), .StallCount(sc[1])
`endif
    );

`ifndef DMEM_STATS_EN
    initial begin
        for (int u = 0; u < 2; u++) begin
            rc[u] = 32'd0;
            wc[u] = 32'd0;
            sc[u] = 32'd0;
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] model_issue(input int u, input bit r, input bit w,
                                                input logic [31:0] a, input logic [31:0] d);
        bit       bad;
        bit       e;
        int       idx;
        bad = (a[1:0] != 2'b00) || (a >= LIMIT);
        e   = bad || (r && w);
        idx = int'(a[9:2]);
        if (w) begin
            if (!bad) begin
                mem_m[u][idx]   = d;
                known_m[u][idx] = 1'b1;
            end
        end else if (bad) begin
            last_rd[u]    = 32'd0;
            last_known[u] = 1'b1;
        end else begin
            last_rd[u]    = mem_m[u][idx];
            last_known[u] = known_m[u][idx];
        end
        return {~last_known[u], e, last_rd[u]};
    endfunction

    task automatic access(input int u, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        logic [33:0] e;
        int          stalls;
        bit          seen;
        e = model_issue(u, r, w, a, d);
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(negedge clk);
        rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
        #1;
        stalls = int'(stall[u]);
        seen   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stalls += int'(stall[u]);
            if (done[u]) begin
                seen = 1'b1;
                break;
            end
        end
        rd[u] = 1'b0; wr[u] = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout u%0d: no MemDoneM within 40 cycles, expected one", u);
        end
        check($sformatf("stall_cycles_u%0d", u), 32'(stalls), 32'((u == 0 ? WS0 : WS1) + 2));
    endtask

    task automatic monitor_unit(input int u);
        logic [33:0] e;
        bit          empty;
        if (err[u] && !done[u]) begin
            checks++;
            failures++;
            $display("FAIL err_without_done u%0d: MemErrM=1 MemDoneM=0, expected paired pulse", u);
        end
        if (done[u]) begin
            empty = (u == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done u%0d: MemDoneM=1 with no access outstanding", u);
            end else begin
                e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("resp_err_u%0d", u), 32'(err[u]), 32'(e[32]));
                if (!e[33]) check($sformatf("resp_rdata_u%0d", u), rdata[u], e[31:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_unit(0);
        monitor_unit(1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          kind;
        int          op;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0;
            addr[u] = 32'd0; wdata[u] = 32'd0;
            last_rd[u] = 32'd0; last_known[u] = 1'b1;
            for (int i = 0; i < DEPTH; i++) known_m[u][i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_rdata_u%0d", u), rdata[u], 32'd0);
            check($sformatf("reset_stall_u%0d", u), 32'(stall[u]), 32'd0);
            check($sformatf("reset_done_u%0d", u), 32'(done[u]), 32'd0);
            check($sformatf("reset_err_u%0d", u), 32'(err[u]), 32'd0);
            rst[u] = 1'b0;
        end

        // Three reads and two writes right after reset; also exercises the statistics.
        access(0, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D);
        access(0, 1'b0, 1'b1, 32'h44, 32'h1357_9BDF);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
        access(0, 1'b1, 1'b0, 32'h44, 32'h0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
`ifdef DMEM_STATS_EN
        check("stats_read_count", rc[0], 32'd3);
        check("stats_write_count", wc[0], 32'd2);
        check("stats_stall_count", sc[0], 32'(5 * (WS0 + 2)));
`endif

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        access(1, 1'b0, 1'b1, 32'h04, 32'h1234_5678);
        access(1, 1'b1, 1'b0, 32'h04, 32'h0);

        access(0, 1'b1, 1'b0, 32'h13, 32'h0);
        access(0, 1'b1, 1'b0, 32'h400, 32'h0);
        access(0, 1'b0, 1'b1, 32'h13, 32'hFFFF_0000);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Store aborted by reset while still waiting: RAM must keep the old word.
        access(0, 1'b0, 1'b1, 32'h08, 32'h1);
        access(0, 1'b1, 1'b0, 32'h08, 32'h0);
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h08; wdata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        rst[0] = 1'b1; wr[0] = 1'b0;
        @(negedge clk);
        check("abort_rdata", rdata[0], 32'd0);
        check("abort_stall", 32'(stall[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_err", 32'(err[0]), 32'd0);
        rst[0] = 1'b0;
        last_rd[0] = 32'd0;
        last_known[0] = 1'b1;
        access(0, 1'b1, 1'b0, 32'h08, 32'h0);

        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            if (kind == 0)      a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = LIMIT + 32'($urandom_range(0, 4095));
            access(n % 2, (op >= 4), (op < 5), a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("leftover_exp_u0", 32'(exp_q0.size()), 32'd0);
        check("leftover_exp_u1", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
